// File: rtl/core_seq.sv
// core_seq: multi-cycle sequencer for the rv32 core datapath.
// Ports: clk_i/reset_i (sync, active-high), run_i/step_i debug control,
//   imem_ready_i/dmem_ready_i memory handshakes, is_mem_i/is_wb_i decode info;
//   tick_o core tick, imem_req_o/dmem_req_o requests, ir_we_o/rf_we_o/pc_we_o
//   one-cycle strobes, state_o/halted_o/fault_o status, instret_o count.
module core_seq #(
    parameter int CLK_DIV     = 100,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        run_i,
    input  logic        step_i,
    input  logic        imem_ready_i,
    input  logic        dmem_ready_i,
    input  logic        is_mem_i,
    input  logic        is_wb_i,
    output logic        tick_o,
    output logic        imem_req_o,
    output logic        dmem_req_o,
    output logic        ir_we_o,
    output logic        rf_we_o,
    output logic        pc_we_o,
    output logic [2:0]  state_o,
    output logic        halted_o,
    output logic        fault_o,
    output logic [31:0] instret_o
);

    typedef enum logic [2:0] {
        S_HALT   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_FAULT  = 3'd7
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0] TIMEOUT  = 8'(MEM_TIMEOUT);

    logic [7:0]  div_cnt;
    logic [7:0]  wait_cnt;
    state_t      state;
    logic        step_pending;
    logic [31:0] instret;

    logic tick;
    logic live_tick;
    logic commit;
    logic wait_expired;

    assign tick      = (div_cnt == DIV_LAST);
    // Strobes are suppressed while reset is asserted so nothing commits
    // in the cycle that is being thrown away.
    assign live_tick = tick & ~reset_i;
    assign commit    = live_tick & (state == S_WB);
    // This tick would be the MEM_TIMEOUT-th one without ready.
    assign wait_expired = ((wait_cnt + 8'd1) == TIMEOUT);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            div_cnt      <= 8'd0;
            wait_cnt     <= 8'd0;
            state        <= S_HALT;
            step_pending <= 1'b0;
            instret      <= 32'd0;
        end else begin
            div_cnt <= tick ? 8'd0 : div_cnt + 8'd1;

            // A step request in the commit cycle survives the clear.
            if (step_i)
                step_pending <= 1'b1;
            else if (commit)
                step_pending <= 1'b0;

            if (tick) begin
                unique case (state)
                    S_HALT: begin
                        if (run_i || step_pending) begin
                            state    <= S_FETCH;
                            wait_cnt <= 8'd0;
                        end
                    end
                    S_FETCH: begin
                        if (imem_ready_i) begin
                            state <= S_DECODE;
                        end else begin
                            wait_cnt <= wait_cnt + 8'd1;
                            if (wait_expired)
                                state <= S_FAULT;
                        end
                    end
                    S_DECODE: begin
                        if (is_mem_i) begin
                            state    <= S_MEM;
                            wait_cnt <= 8'd0;
                        end else begin
                            state <= S_WB;
                        end
                    end
                    S_MEM: begin
                        if (dmem_ready_i) begin
                            state <= S_WB;
                        end else begin
                            wait_cnt <= wait_cnt + 8'd1;
                            if (wait_expired)
                                state <= S_FAULT;
                        end
                    end
                    S_WB: begin
                        instret <= instret + 32'd1;
                        if (run_i) begin
                            state    <= S_FETCH;
                            wait_cnt <= 8'd0;
                        end else begin
                            state <= S_HALT;
                        end
                    end
                    default: state <= S_FAULT;
                endcase
            end
        end
    end

    assign tick_o     = tick;
    assign imem_req_o = (state == S_FETCH);
    assign dmem_req_o = (state == S_MEM);
    assign ir_we_o    = live_tick & (state == S_FETCH) & imem_ready_i;
    assign pc_we_o    = commit;
    assign rf_we_o    = commit & is_wb_i;
    assign state_o    = state;
    assign halted_o   = (state == S_HALT);
    assign fault_o    = (state == S_FAULT);
    assign instret_o  = instret;

endmodule

// File: tb/tb_core_seq.sv
// tb_core_seq: self-checking bench for core_seq.
// Two instances: CLK_DIV=4 and CLK_DIV=1, both MEM_TIMEOUT=15.
module tb_core_seq;

    localparam int DIV4 = 4;
    localparam int TO   = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic run, step, ir, dr, mem, wb;
    logic rst4, rst1;

    logic        tick4, ireq4, dreq4, irwe4, rfwe4, pcwe4, hlt4, flt4;
    logic [2:0]  st4;
    logic [31:0] ret4;
    logic        tick1, ireq1, dreq1, irwe1, rfwe1, pcwe1, hlt1, flt1;
    logic [2:0]  st1;
    logic [31:0] ret1;

    core_seq #(.CLK_DIV(DIV4), .MEM_TIMEOUT(TO)) dut4 (
        .clk_i(clk), .reset_i(rst4), .run_i(run), .step_i(step),
        .imem_ready_i(ir), .dmem_ready_i(dr), .is_mem_i(mem), .is_wb_i(wb),
        .tick_o(tick4), .imem_req_o(ireq4), .dmem_req_o(dreq4),
        .ir_we_o(irwe4), .rf_we_o(rfwe4), .pc_we_o(pcwe4),
        .state_o(st4), .halted_o(hlt4), .fault_o(flt4), .instret_o(ret4)
    );

    core_seq #(.CLK_DIV(1), .MEM_TIMEOUT(TO)) dut1 (
        .clk_i(clk), .reset_i(rst1), .run_i(run), .step_i(step),
        .imem_ready_i(ir), .dmem_ready_i(dr), .is_mem_i(mem), .is_wb_i(wb),
        .tick_o(tick1), .imem_req_o(ireq1), .dmem_req_o(dreq1),
        .ir_we_o(irwe1), .rf_we_o(rfwe1), .pc_we_o(pcwe1),
        .state_o(st1), .halted_o(hlt1), .fault_o(flt1), .instret_o(ret1)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Leaves the DUT in cycle 1 after reset, divider at 0.
    task automatic reset4();
        rst4 = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst4 = 1'b0;
    endtask

    typedef struct {
        logic rst, run, step, ir, dr, mem, wb;
        logic [2:0] st;
        logic irwe, rfwe, pcwe, ireq, dreq;
        logic [31:0] ret;
    } vec_t;

    function automatic vec_t mk(
        logic a_rst, logic a_run, logic a_step, logic a_ir, logic a_dr,
        logic a_mem, logic a_wb, logic [2:0] a_st, logic a_irwe,
        logic a_rfwe, logic a_pcwe, logic a_ireq, logic a_dreq,
        logic [31:0] a_ret);
        vec_t v;
        v.rst = a_rst; v.run = a_run; v.step = a_step; v.ir = a_ir;
        v.dr = a_dr; v.mem = a_mem; v.wb = a_wb; v.st = a_st;
        v.irwe = a_irwe; v.rfwe = a_rfwe; v.pcwe = a_pcwe;
        v.ireq = a_ireq; v.dreq = a_dreq; v.ret = a_ret;
        return v;
    endfunction

    vec_t tbl[26];

    // Spec-level reference for the CLK_DIV=4 instance.
    // Phases: 0 halt, 1 fetch, 2 decode, 3 mem, 4 wb, 7 fault.
    int          m_cyc;
    int          m_ph;
    int          m_waits;
    bit          m_pend;
    int unsigned m_ret;

    task automatic model_reset();
        m_cyc = 0; m_ph = 0; m_waits = 0; m_pend = 0; m_ret = 0;
    endtask

    task automatic model_edge();
        bit t;
        t = ((m_cyc % DIV4) == DIV4 - 1);
        if (rst4) begin
            model_reset();
            return;
        end
        m_cyc++;
        if (t) begin
            if (m_ph == 0) begin
                if (run || m_pend) begin m_ph = 1; m_waits = 0; end
            end else if (m_ph == 1 || m_ph == 3) begin
                if ((m_ph == 1) ? ir : dr) m_ph = (m_ph == 1) ? 2 : 4;
                else begin
                    m_waits++;
                    if (m_waits >= TO) m_ph = 7;
                end
            end else if (m_ph == 2) begin
                m_ph = mem ? 3 : 4;
                m_waits = 0;
            end else if (m_ph == 4) begin
                m_ret++;
                m_pend = 0;
                m_ph = run ? 1 : 0;
                m_waits = 0;
            end
        end
        if (step) m_pend = 1;
    endtask

    int mem_ticks, itk, rfc, pcc, dreq_bad, fticks, junk, base;

    initial begin
        run = 0; step = 0; ir = 0; dr = 0; mem = 0; wb = 0;
        rst4 = 1; rst1 = 1;
        repeat (3) @(posedge clk);
        #1;

        tbl[0]  = mk(1,0,0,1,1,0,1, 0,0,0,0,0,0, 0);
        tbl[1]  = mk(0,1,0,1,1,0,1, 0,0,0,0,0,0, 0);
        tbl[2]  = mk(0,1,0,1,1,0,1, 1,1,0,0,1,0, 0);
        tbl[3]  = mk(0,1,0,1,1,0,1, 2,0,0,0,0,0, 0);
        tbl[4]  = mk(0,1,0,1,1,0,1, 4,0,1,1,0,0, 0);
        tbl[5]  = mk(0,1,0,1,1,0,1, 1,1,0,0,1,0, 1);
        tbl[6]  = mk(0,1,0,1,1,1,1, 2,0,0,0,0,0, 1);
        tbl[7]  = mk(0,1,0,1,0,1,1, 3,0,0,0,0,1, 1);
        tbl[8]  = mk(0,1,0,1,1,1,1, 3,0,0,0,0,1, 1);
        tbl[9]  = mk(0,0,0,1,1,1,0, 4,0,0,1,0,0, 1);
        tbl[10] = mk(0,0,0,1,1,0,0, 0,0,0,0,0,0, 2);
        tbl[11] = mk(0,0,1,1,1,0,0, 0,0,0,0,0,0, 2);
        tbl[12] = mk(0,0,0,1,1,0,0, 0,0,0,0,0,0, 2);
        tbl[13] = mk(0,0,0,1,1,0,1, 1,1,0,0,1,0, 2);
        tbl[14] = mk(0,0,0,1,1,0,1, 2,0,0,0,0,0, 2);
        tbl[15] = mk(0,0,0,1,1,0,1, 4,0,1,1,0,0, 2);
        tbl[16] = mk(0,0,0,1,1,0,1, 0,0,0,0,0,0, 3);
        tbl[17] = mk(0,1,0,1,1,1,1, 0,0,0,0,0,0, 3);
        tbl[18] = mk(0,1,0,1,1,1,1, 1,1,0,0,1,0, 3);
        tbl[19] = mk(0,1,0,1,1,1,1, 2,0,0,0,0,0, 3);
        tbl[20] = mk(1,1,0,1,1,1,1, 3,0,0,0,0,1, 3);
        tbl[21] = mk(0,1,0,1,1,0,1, 0,0,0,0,0,0, 0);
        tbl[22] = mk(0,1,0,1,1,0,1, 1,1,0,0,1,0, 0);
        tbl[23] = mk(0,1,0,1,1,0,1, 2,0,0,0,0,0, 0);
        tbl[24] = mk(1,1,0,1,1,0,1, 4,0,0,0,0,0, 0);
        tbl[25] = mk(0,0,0,1,1,0,1, 0,0,0,0,0,0, 0);

        // Table on the CLK_DIV=1 instance: every cycle is a tick.
        for (int i = 0; i < 26; i++) begin
            rst1 = tbl[i].rst; run = tbl[i].run; step = tbl[i].step;
            ir = tbl[i].ir; dr = tbl[i].dr; mem = tbl[i].mem; wb = tbl[i].wb;
            @(negedge clk);
            check($sformatf("tbl%0d tick", i), tick1, 1);
            check($sformatf("tbl%0d state", i), st1, tbl[i].st);
            check($sformatf("tbl%0d ir_we", i), irwe1, tbl[i].irwe);
            check($sformatf("tbl%0d rf_we", i), rfwe1, tbl[i].rfwe);
            check($sformatf("tbl%0d pc_we", i), pcwe1, tbl[i].pcwe);
            check($sformatf("tbl%0d imem_req", i), ireq1, tbl[i].ireq);
            check($sformatf("tbl%0d dmem_req", i), dreq1, tbl[i].dreq);
            check($sformatf("tbl%0d instret", i), ret1, tbl[i].ret);
            check($sformatf("tbl%0d halted", i), hlt1, tbl[i].st == 3'd0);
            cyc();
        end

        // CLK_DIV=1 free run: 4 retirements in 13 cycles.
        run = 1; step = 0; ir = 1; dr = 1; mem = 0; wb = 1;
        rst1 = 1; cyc(); rst1 = 0;
        repeat (13) cyc();
        check("div1 instret13", ret1, 4);
        rst1 = 1;

        // Free run at CLK_DIV=4: tick cadence and strobe counts.
        reset4();
        rfc = 0; pcc = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            check($sformatf("run tick c%0d", c), tick4, (c % 4) == 0);
            if (rfwe4) rfc++;
            if (pcwe4) pcc++;
            cyc();
        end
        check("run instret", ret4, 3);
        check("run rf_we pulses", rfc, 3);
        check("run pc_we pulses", pcc, 3);

        // Single step from halt, twice.
        run = 0;
        reset4();
        step = 1; cyc(); step = 0;
        for (int k = 0; k < 200 && ret4 != 1; k++) cyc();
        check("step1 instret", ret4, 1);
        check("step1 halted", hlt4, 1);
        repeat (40) cyc();
        check("step1 no extra", ret4, 1);
        step = 1; cyc(); step = 0;
        for (int k = 0; k < 200 && ret4 != 2; k++) cyc();
        check("step2 instret", ret4, 2);
        check("step2 state", st4, 0);

        // Memory instruction with two not-ready MEM ticks.
        run = 1; mem = 1; wb = 1; ir = 1; dr = 0;
        reset4();
        mem_ticks = 0; itk = 0; rfc = 0; dreq_bad = 0;
        for (int k = 0; k < 400 && ret4 < 1; k++) begin
            @(negedge clk);
            if (st4 == 3'd3) begin
                if (dreq4 !== 1'b1) dreq_bad++;
                if (tick4) begin
                    dr = (mem_ticks >= 2);
                    mem_ticks++;
                end
            end
            if (tick4 && st4 != 3'd0) itk++;
            if (rfwe4) rfc++;
            cyc();
        end
        check("mem ticks in MEM", mem_ticks, 3);
        check("mem instr ticks", itk, 6);
        check("mem dmem_req held", dreq_bad, 0);
        check("mem rf_we wb=1", rfc, 1);
        wb = 0; dr = 1; rfc = 0; pcc = 0;
        for (int k = 0; k < 400 && ret4 < 2; k++) begin
            @(negedge clk);
            if (rfwe4) rfc++;
            if (pcwe4) pcc++;
            cyc();
        end
        check("mem rf_we wb=0", rfc, 0);
        check("mem pc_we wb=0", pcc, 1);

        // Fetch timeout into FAULT, then reset out of it.
        run = 1; ir = 0; dr = 1; mem = 0; wb = 1;
        reset4();
        fticks = 0;
        for (int k = 0; k < 400 && st4 != 3'd7; k++) begin
            @(negedge clk);
            if (tick4 && st4 == 3'd1) fticks++;
            cyc();
        end
        check("fault fetch ticks", fticks, 15);
        check("fault state", st4, 7);
        check("fault flag", flt4, 1);
        ir = 1; junk = 0;
        repeat (40) begin
            @(negedge clk);
            if (irwe4 || rfwe4 || pcwe4 || ireq4 || dreq4) junk++;
            cyc();
        end
        check("fault quiet", junk, 0);
        check("fault sticky", st4, 7);
        reset4();
        check("post-fault state", st4, 0);
        check("post-fault instret", ret4, 0);
        check("post-fault flag", flt4, 0);
        check("post-fault halted", hlt4, 1);

        // Drop run during DECODE: finish through WB, then halt.
        run = 1; ir = 1; dr = 1; mem = 0; wb = 1;
        reset4();
        for (int k = 0; k < 200 && st4 != 3'd2; k++) cyc();
        run = 0;
        base = ret4;
        pcc = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (pcwe4) pcc++;
            cyc();
        end
        check("drop pc_we pulses", pcc, 1);
        check("drop instret", ret4, base + 1);
        check("drop state", st4, 0);

        // Randomized run against the reference model.
        run = 1; step = 0;
        reset4();
        model_reset();
        for (int k = 0; k < 3000; k++) begin
            bit t, live;
            if ($urandom_range(0, 39) == 0) run = ~run;
            step = ($urandom_range(0, 29) == 0);
            ir   = ($urandom_range(0, 3) != 0);
            dr   = ($urandom_range(0, 3) != 0);
            mem  = $urandom_range(0, 1) == 1;
            wb   = $urandom_range(0, 1) == 1;
            rst4 = ($urandom_range(0, 699) == 0);
            @(negedge clk);
            t    = ((m_cyc % DIV4) == DIV4 - 1);
            live = t && !rst4;
            check("rnd tick", tick4, t);
            check("rnd state", st4, m_ph);
            check("rnd imem_req", ireq4, m_ph == 1);
            check("rnd dmem_req", dreq4, m_ph == 3);
            check("rnd ir_we", irwe4, live && m_ph == 1 && ir);
            check("rnd pc_we", pcwe4, live && m_ph == 4);
            check("rnd rf_we", rfwe4, live && m_ph == 4 && wb);
            check("rnd halted", hlt4, m_ph == 0);
            check("rnd fault", flt4, m_ph == 7);
            check("rnd instret", ret4, m_ret);
            model_edge();
            cyc();
        end
        rst4 = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
